delay_demux: RTL

DELAY_DEMUX -- requirements
Module: delay_demux

---
 rtl/delay_demux_pkg.sv | 10 +
 rtl/delay_pipe.sv | 53 +++++
 rtl/delay_demux.sv | 70 +++++++
 3 files changed

// File: rtl/delay_demux_pkg.sv
// Shared constants for the delay demultiplexer: default data width, legal
// delay range and delivered-item counter width.
package delay_demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DLY_MIN   = 1;
  localparam int DLY_MAX   = 8;
  localparam int COUNT_W   = 8;

endpackage : delay_demux_pkg

// File: rtl/delay_pipe.sv
// Fixed-latency valid+data shift pipeline. Data is zeroed on bubbles so the
// output word reads 0 whenever its valid bit is low.
module delay_pipe
  import delay_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             vld_nxt,
  output logic             busy
);

  if (DEPTH < DLY_MIN || DEPTH > DLY_MAX) begin : g_bad_depth
    $error("delay_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DLY_MIN, DLY_MAX);
  end

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  // NOTE: every stage, data included, is reset here so a flushed word can
  // never reappear; this array is small flops, not a RAM, so the reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= push_vld;
      dat_q[0] <= push_vld ? push_dat : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld  = vld_q[DEPTH-1];
  assign dat  = dat_q[DEPTH-1];
  assign busy = |vld_q;

  // Valid bit that will appear on the output after the next edge.
  if (DEPTH == 1) begin : g_nxt_d1
    assign vld_nxt = push_vld;
  end else begin : g_nxt_dn
    assign vld_nxt = vld_q[DEPTH-2];
  end

endmodule : delay_pipe

// File: rtl/delay_demux.sv
// Routes each valid input word to channel A or B, each with its own fixed delay.
// Optional per-channel delivered counters: define DELAY_DEMUX_COUNT_EN.
module delay_demux
  import delay_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DLY0  = 3,
  parameter int DLY1  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   y,
  input  logic               y_vld,
  input  logic               Sel,
  output logic [WIDTH-1:0]   A,
  output logic               A_vld,
  output logic [WIDTH-1:0]   B,
  output logic               B_vld,
  output logic               busy
`ifdef DELAY_DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] cntA,
  output logic [COUNT_W-1:0] cntB
`endif
);

  logic a_busy, b_busy;
  logic a_vld_nxt, b_vld_nxt;

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(DLY0)) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (y_vld & ~Sel),
    .push_dat (y),
    .vld      (A_vld),
    .dat      (A),
    .vld_nxt  (a_vld_nxt),
    .busy     (a_busy)
  );

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(DLY1)) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (y_vld & Sel),
    .push_dat (y),
    .vld      (B_vld),
    .dat      (B),
    .vld_nxt  (b_vld_nxt),
    .busy     (b_busy)
  );

  assign busy = a_busy | b_busy;

`ifdef DELAY_DEMUX_COUNT_EN
  // Count on the same edge that presents a new word on the channel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntA <= '0;
      cntB <= '0;
    end else begin
      if (a_vld_nxt) cntA <= cntA + COUNT_W'(1);
      if (b_vld_nxt) cntB <= cntB + COUNT_W'(1);
    end
  end
`else
  logic unused_vld_nxt;
  assign unused_vld_nxt = a_vld_nxt | b_vld_nxt;
`endif

endmodule : delay_demux
